// File: rtl/seg7_score_ctrl.sv
// seg7_score_ctrl
//   BCD score keeper and display sequencer for the Snake game's 7-segment bank.
//   Counts score events in packed BCD, blanks leading zeros and blinks the
//   whole bank while game-over is flagged. Each 4-bit slice of oDIG feeds one
//   SEG7_LUT instance. Code 4'hA is that LUT's all-segments-off code.
//
// Ports
//   iCLK          system clock
//   iRST          asynchronous, active-high reset
//   iINC          score +1 on every edge where high (level-sampled)
//   iCLR          synchronous clear of score and oOVF (wins over iINC)
//   iBLINK_EN     high = game over, blink the display
//   oDIG          registered digit codes, [3:0] = least significant digit
//   oOVF          sticky: score passed all-9s since the last clear/reset
//   oBLINK_STATE  current blink phase (0 = ON, 1 = OFF), for observation
//
// Handshake: there is no valid/ready flow here. iINC and iCLR are level
// inputs acted on at every rising edge of iCLK where they are high.
module seg7_score_ctrl #(
  parameter int NDIG      = 4,
  parameter int BLINK_DIV = 25_000_000,
  parameter bit SATURATE  = 1'b0,
  parameter bit LZB       = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iINC,
  input  logic              iCLR,
  input  logic              iBLINK_EN,
  output logic [4*NDIG-1:0] oDIG,
  output logic              oOVF,
  output logic [0:0]        oBLINK_STATE
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  localparam logic [0:0] PH_ON  = 1'b0;
  localparam logic [0:0] PH_OFF = 1'b1;

  localparam logic [3:0] BLANK = 4'hA;

  // Display value while in reset: only digit 0 is visible when blanking.
  localparam logic [4*NDIG-1:0] RST_DIG =
    LZB ? {{(NDIG-1){BLANK}}, 4'h0} : '0;

  logic [4*NDIG-1:0] score_q, score_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [0:0]        phase_q, phase_d;
  logic [4*NDIG-1:0] disp_q, disp_d;

  logic [4*NDIG-1:0] inc_val;
  logic              all9;

  // Ripple-carry BCD +1. The carry surviving past the top digit means the
  // score was all-9s, and the wrapped value is then all zeros.
  always_comb begin
    inc_val = score_q;
    all9    = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (all9) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          all9 = 1'b0;
        end
      end
    end
  end

  always_comb begin
    score_d = score_q;
    ovf_d   = ovf_q;
    if (iCLR) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (iINC) begin
      if (all9) begin
        ovf_d   = 1'b1;
        score_d = SATURATE ? score_q : inc_val;
      end else begin
        score_d = inc_val;
      end
    end
  end

  // Blink phase machine: the counter only runs while blinking is enabled,
  // so the first ON->OFF toggle lands BLINK_DIV edges after enable.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!iBLINK_EN) begin
      cnt_d   = '0;
      phase_d = PH_ON;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Display is built from next-state values so it lines up with the score
  // and phase registers on the same edge.
  always_comb begin
    logic hi_zero;
    disp_d  = '0;
    hi_zero = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (score_d[4*i +: 4] == 4'd0);
      if (phase_d == PH_OFF) begin
        disp_d[4*i +: 4] = BLANK;
      end else if (LZB && (i >= 1) && hi_zero) begin
        disp_d[4*i +: 4] = BLANK;
      end else begin
        disp_d[4*i +: 4] = score_d[4*i +: 4];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      score_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      phase_q <= PH_ON;
      disp_q  <= RST_DIG;
    end else begin
      score_q <= score_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      disp_q  <= disp_d;
    end
  end

  assign oDIG         = disp_q;
  assign oOVF         = ovf_q;
  assign oBLINK_STATE = phase_q;

endmodule

// File: tb/tb_seg7_score_ctrl.sv
module tb_seg7_score_ctrl;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic inc = 1'b0;
  logic clr = 1'b0;
  logic blink_en = 1'b0;

  logic [15:0] dig_a, dig_s, dig_n;
  logic        ovf_a, ovf_s, ovf_n;
  logic [0:0]  ph_a, ph_s, ph_n;

  int n_pass  = 0;
  int n_total = 0;

  // Default build: wrap on overflow, leading-zero blanking.
  seg7_score_ctrl #(.NDIG(4), .BLINK_DIV(4), .SATURATE(1'b0), .LZB(1'b1)) dut_a (
    .iCLK(clk), .iRST(rst), .iINC(inc), .iCLR(clr), .iBLINK_EN(blink_en),
    .oDIG(dig_a), .oOVF(ovf_a), .oBLINK_STATE(ph_a)
  );

  // Saturating build.
  seg7_score_ctrl #(.NDIG(4), .BLINK_DIV(4), .SATURATE(1'b1), .LZB(1'b1)) dut_s (
    .iCLK(clk), .iRST(rst), .iINC(inc), .iCLR(clr), .iBLINK_EN(blink_en),
    .oDIG(dig_s), .oOVF(ovf_s), .oBLINK_STATE(ph_s)
  );

  // No leading-zero blanking.
  seg7_score_ctrl #(.NDIG(4), .BLINK_DIV(4), .SATURATE(1'b0), .LZB(1'b0)) dut_n (
    .iCLK(clk), .iRST(rst), .iINC(inc), .iCLR(clr), .iBLINK_EN(blink_en),
    .oDIG(dig_n), .oOVF(ovf_n), .oBLINK_STATE(ph_n)
  );

  // ---------------------------------------------------------------- driver tasks
  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    tick(2);
    #2;            // mid-cycle
    rst = 1'b1;
    #1;            // before the next edge
    n_total++;
    if (dig_a !== 16'hAAA0) $display("FAIL reset_dig_a got %h exp %h", dig_a, 16'hAAA0);
    else n_pass++;
    n_total++;
    if (ovf_a !== 1'b0) $display("FAIL reset_ovf_a got %b exp 0", ovf_a);
    else n_pass++;
    n_total++;
    if (dig_n !== 16'h0000) $display("FAIL reset_dig_n got %h exp 0000", dig_n);
    else n_pass++;
    n_total++;
    if (ph_a !== 1'b0) $display("FAIL reset_phase got %b exp 0", ph_a);
    else n_pass++;
    tick(1);
    rst = 1'b0;
    tick(1);
    n_total++;
    if (dig_a !== 16'hAAA0) $display("FAIL reset_idle_dig got %h exp %h", dig_a, 16'hAAA0);
    else n_pass++;
  endtask

  task automatic test_counting();
    inc = 1'b1;
    tick(3);
    n_total++;
    if (dig_a !== 16'hAAA3) $display("FAIL count3 got %h exp %h", dig_a, 16'hAAA3);
    else n_pass++;
    n_total++;
    if (dig_n !== 16'h0003) $display("FAIL count3_nolzb got %h exp %h", dig_n, 16'h0003);
    else n_pass++;
    tick(7);
    n_total++;
    if (dig_a !== 16'hAA10) $display("FAIL count10 got %h exp %h", dig_a, 16'hAA10);
    else n_pass++;
    tick(90);
    n_total++;
    if (dig_a !== 16'hA100) $display("FAIL count100 got %h exp %h", dig_a, 16'hA100);
    else n_pass++;
    inc = 1'b0;
    tick(2);
    n_total++;
    if (dig_a !== 16'hA100) $display("FAIL count_hold got %h exp %h", dig_a, 16'hA100);
    else n_pass++;
  endtask

  task automatic test_overflow();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    inc = 1'b1;
    tick(9999);
    n_total++;
    if (dig_a !== 16'h9999) $display("FAIL ovf_pre_dig got %h exp 9999", dig_a);
    else n_pass++;
    n_total++;
    if (ovf_a !== 1'b0) $display("FAIL ovf_pre_flag got %b exp 0", ovf_a);
    else n_pass++;
    tick(1);
    n_total++;
    if (dig_a !== 16'hAAA0) $display("FAIL ovf_wrap_dig got %h exp %h", dig_a, 16'hAAA0);
    else n_pass++;
    n_total++;
    if (ovf_a !== 1'b1) $display("FAIL ovf_wrap_flag got %b exp 1", ovf_a);
    else n_pass++;
    n_total++;
    if (dig_s !== 16'h9999) $display("FAIL ovf_sat_dig got %h exp 9999", dig_s);
    else n_pass++;
    n_total++;
    if (ovf_s !== 1'b1) $display("FAIL ovf_sat_flag got %b exp 1", ovf_s);
    else n_pass++;
    n_total++;
    if (dig_n !== 16'h0000) $display("FAIL ovf_nolzb_dig got %h exp 0000", dig_n);
    else n_pass++;
    // one more increment: wrap build counts on, flag stays sticky
    tick(1);
    inc = 1'b0;
    n_total++;
    if (dig_a !== 16'hAAA1) $display("FAIL ovf_after_dig got %h exp %h", dig_a, 16'hAAA1);
    else n_pass++;
    n_total++;
    if (ovf_a !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf_a);
    else n_pass++;
    n_total++;
    if (dig_s !== 16'h9999) $display("FAIL ovf_sat_hold got %h exp 9999", dig_s);
    else n_pass++;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_total++;
    if (ovf_a !== 1'b0) $display("FAIL clr_ovf_a got %b exp 0", ovf_a);
    else n_pass++;
    n_total++;
    if (ovf_s !== 1'b0) $display("FAIL clr_ovf_s got %b exp 0", ovf_s);
    else n_pass++;
    n_total++;
    if (dig_s !== 16'hAAA0) $display("FAIL clr_dig_s got %h exp %h", dig_s, 16'hAAA0);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    inc = 1'b1;
    tick(57);
    n_total++;
    if (dig_a !== 16'hAA57) $display("FAIL sim_pre got %h exp %h", dig_a, 16'hAA57);
    else n_pass++;
    clr = 1'b1;        // inc still high in the same cycle
    tick(1);
    clr = 1'b0;
    inc = 1'b0;
    n_total++;
    if (dig_a !== 16'hAAA0) $display("FAIL sim_dig got %h exp %h", dig_a, 16'hAAA0);
    else n_pass++;
    n_total++;
    if (ovf_a !== 1'b0) $display("FAIL sim_ovf got %b exp 0", ovf_a);
    else n_pass++;
  endtask

  task automatic test_blink();
    inc = 1'b1;
    tick(42);
    inc = 1'b0;
    blink_en = 1'b1;
    // current value plus 3 edges of ON
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (dig_a !== 16'hAA42) $display("FAIL blink_on%0d got %h exp %h", i, dig_a, 16'hAA42);
      else n_pass++;
      if (i < 3) tick(1);
    end
    tick(1);
    n_total++;
    if (dig_a !== 16'hAAAA) $display("FAIL blink_off0 got %h exp AAAA", dig_a);
    else n_pass++;
    n_total++;
    if (ph_a !== 1'b1) $display("FAIL blink_phase_off got %b exp 1", ph_a);
    else n_pass++;
    inc = 1'b1;        // single pulse while OFF
    tick(1);
    inc = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_total++;
      if (dig_a !== 16'hAAAA) $display("FAIL blink_off%0d got %h exp AAAA", i, dig_a);
      else n_pass++;
      if (i < 3) tick(1);
    end
    tick(1);
    n_total++;
    if (dig_a !== 16'hAA43) $display("FAIL blink_on_again got %h exp %h", dig_a, 16'hAA43);
    else n_pass++;
    n_total++;
    if (ph_a !== 1'b0) $display("FAIL blink_phase_on got %b exp 0", ph_a);
    else n_pass++;
    tick(4);           // into the next OFF phase
    n_total++;
    if (dig_a !== 16'hAAAA) $display("FAIL blink_off_second got %h exp AAAA", dig_a);
    else n_pass++;
    blink_en = 1'b0;
    tick(1);
    n_total++;
    if (dig_a !== 16'hAA43) $display("FAIL blink_drop got %h exp %h", dig_a, 16'hAA43);
    else n_pass++;
  endtask

  task automatic test_display_options();
    blink_en = 1'b1;
    tick(4);
    n_total++;
    if (dig_n !== 16'hAAAA) $display("FAIL opt_off_nolzb got %h exp AAAA", dig_n);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (dig_n !== 16'h0000) $display("FAIL opt_rst_nolzb got %h exp 0000", dig_n);
    else n_pass++;
    n_total++;
    if (dig_a !== 16'hAAA0) $display("FAIL opt_rst_lzb got %h exp %h", dig_a, 16'hAAA0);
    else n_pass++;
    n_total++;
    if (ph_a !== 1'b0) $display("FAIL opt_rst_phase got %b exp 0", ph_a);
    else n_pass++;
    tick(1);
    rst = 1'b0;
    // blink still enabled: counter restarted, so 3 ON edges then OFF
    tick(3);
    n_total++;
    if (dig_n !== 16'h0000) $display("FAIL opt_release_on got %h exp 0000", dig_n);
    else n_pass++;
    tick(1);
    n_total++;
    if (dig_n !== 16'hAAAA) $display("FAIL opt_release_off got %h exp AAAA", dig_n);
    else n_pass++;
    blink_en = 1'b0;
    inc = 1'b1;
    tick(7);
    inc = 1'b0;
    n_total++;
    if (dig_n !== 16'h0007) $display("FAIL opt_nolzb7 got %h exp %h", dig_n, 16'h0007);
    else n_pass++;
    n_total++;
    if (dig_a !== 16'hAAA7) $display("FAIL opt_lzb7 got %h exp %h", dig_a, 16'hAAA7);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_counting();
    test_overflow();
    test_simultaneous();
    test_blink();
    test_display_options();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
